// File: rtl/sha3_pkg.sv
// Shared Keccak/SHA-3 constants and the digest serializer state encoding.
package sha3_pkg;

    localparam int STATE_W       = 1600;
    localparam int LANE_W        = 64;
    localparam int WORD_W        = 32;
    localparam int RATE_512_W    = 576;
    localparam int MAX_OUT_WORDS = RATE_512_W / WORD_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/byte_swap32.sv
// 32-bit byte reversal: turns a big-endian slice of a lane into Keccak
// little-endian byte order.
module byte_swap32
    import sha3_pkg::*;
(
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    assign dout = {din[7:0], din[15:8], din[23:16], din[31:24]};

endmodule

// File: rtl/keccak_digest_serializer.sv
// Keccak digest serializer: captures the leading OUT_WORDS*32 bits of a
// finished permutation state and streams them out as 32-bit words over a
// valid/ready interface, word 0 first (most significant bits of lane 0).
// Optional build macro KECCAK_DIGEST_BYTESWAP_EN byte-reverses every output
// word; handshake and timing are identical with or without it.
module keccak_digest_serializer
    import sha3_pkg::*;
#(
    parameter int OUT_WORDS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [STATE_W-1:0] in_state,
    output logic               in_ready,
    input  logic               clear,
    output logic               out_valid,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy
);

    localparam int               HOLD_W   = OUT_WORDS * WORD_W;
    localparam int               IDX_W    = $clog2(OUT_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_WORDS - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [WORD_W-1:0]   raw_word;
    logic [WORD_W-1:0]   sel_word;
    logic                sending;
    logic                at_last;
    logic                unused_state_bits;

    // Only the leading digest bits are ever read; the rest of the state is dropped.
    assign unused_state_bits = ^in_state[STATE_W-HOLD_W-1:0];

    assign sending   = (state_q == SEND);
    assign at_last   = (idx_q == LAST_IDX);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = sending;
    assign busy      = sending;
    assign out_last  = sending && at_last;
    // Gated so the bus reads zero whenever no word is offered.
    assign out_data  = sending ? sel_word : '0;

    // Select the held word addressed by the index (index past the end reads zero).
    always_comb begin
        raw_word = '0;
        for (int k = 0; k < OUT_WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                raw_word = hold_q[HOLD_W-1-WORD_W*k -: WORD_W];
            end
        end
    end

`ifdef KECCAK_DIGEST_BYTESWAP_EN
    byte_swap32 u_byte_swap (
        .din  (raw_word),
        .dout (sel_word)
    );
`else
    assign sel_word = raw_word;
`endif

    // Next-state logic: clear wins over capture and transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        hold_d  = in_state[STATE_W-1 -: HOLD_W];
                        idx_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        idx_d = idx_q + IDX_W'(1);
                        if (at_last) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, index and holding register; reset aborts asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

endmodule
